// File: rtl/atd_pkg.sv
// atd_pkg: shared state encoding and default sizing for the ATD receive path.
package atd_pkg;
   localparam int ATD_WORD_BITS   = 16;
   localparam int ATD_FRAME_WORDS = 8;
   localparam int ATD_SYNC_STAGES = 2;
   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} atd_rx_state_t;
endpackage

// File: rtl/atd_edge_sync.sv
// atd_edge_sync: synchronises ATD clock/data and strobes once per ATD clock rising edge.
module atd_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic i_atd_clk,
   input  logic i_atd_data,
   output logic o_shift_en,
   output logic o_sync_data
);
   logic [STAGES-1:0] r_clk_sync;
   logic [STAGES-1:0] r_data_sync;
   logic              r_prev_clk;
   assign o_shift_en  = r_clk_sync[STAGES-1] & ~r_prev_clk;
   assign o_sync_data = r_data_sync[STAGES-1];
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_clk_sync  <= '0;
         r_data_sync <= '0;
         r_prev_clk  <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[STAGES-2:0], i_atd_clk};
         r_data_sync <= {r_data_sync[STAGES-2:0], i_atd_data};
         r_prev_clk  <= r_clk_sync[STAGES-1];
      end
endmodule

// File: rtl/flex_counter.sv
// flex_counter: clearable enabled counter wrapping to 0 after MAX, flags terminal count.
module flex_counter #(
   parameter int W   = 4,
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic n_rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_last
);
   logic [W-1:0] r_cnt;
   assign o_last = (r_cnt == W'(MAX));
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst)       r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_en)    r_cnt <= o_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/atd_rx_controller.sv
// atd_rx_controller: captures one ATD serial frame as MSB-first words and hands
// them to a consumer over a valid/taken handshake, pulsing frame_done at the end.
module atd_rx_controller
   import atd_pkg::*;
#(
   parameter int WORD_BITS   = ATD_WORD_BITS,
   parameter int FRAME_WORDS = ATD_FRAME_WORDS,
   parameter int SYNC_STAGES = ATD_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 i_atd_clk,
   input  logic                 i_atd_data,
   input  logic                 i_atd_enable,
   input  logic                 i_word_taken,
   output logic [WORD_BITS-1:0] o_word_out,
   output logic                 o_word_valid,
   output logic                 o_frame_done,
   output logic                 o_overrun,
   output logic                 o_busy
);
   localparam int BC_W = $clog2(WORD_BITS);
   localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   atd_rx_state_t        r_state, w_next;
   logic [WORD_BITS-2:0] r_shreg;
   logic [WORD_BITS-1:0] r_word_out, w_word;
   logic                 r_word_valid, r_overrun;
   logic                 w_shift_en, w_sync_data, w_shift, w_complete, w_load, w_start;
   logic                 w_bit_last, w_word_last;

   atd_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .n_rst(n_rst), .i_atd_clk(i_atd_clk), .i_atd_data(i_atd_data),
      .o_shift_en(w_shift_en), .o_sync_data(w_sync_data)
   );

   flex_counter #(.W(BC_W), .MAX(WORD_BITS-1)) u_bit_cnt (
      .clk(clk), .n_rst(n_rst), .i_clear(w_start), .i_en(w_shift), .o_last(w_bit_last)
   );

   flex_counter #(.W(WC_W), .MAX(FRAME_WORDS-1)) u_word_cnt (
      .clk(clk), .n_rst(n_rst), .i_clear(w_start), .i_en(w_complete), .o_last(w_word_last)
   );

   // An abort in the same cycle as a strobe wins, so the partial word is never completed.
   assign w_start    = (r_state == IDLE) && i_atd_enable;
   assign w_shift    = (r_state == RECV) && i_atd_enable && w_shift_en;
   assign w_complete = w_shift && w_bit_last;
   assign w_word     = {r_shreg, w_sync_data};
   assign w_load     = w_complete && (!r_word_valid || i_word_taken);

   assign o_word_out   = r_word_out;
   assign o_word_valid = r_word_valid;
   assign o_overrun    = r_overrun;
   assign o_frame_done = (r_state == DONE);
   assign o_busy       = (r_state != IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_atd_enable ? RECV : IDLE;
         RECV:    w_next = !i_atd_enable ? IDLE : (w_complete && w_word_last) ? DRAIN : RECV;
         DRAIN:   w_next = (!r_word_valid || i_word_taken) ? DONE : DRAIN;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) r_state <= IDLE;
      else        r_state <= w_next;

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_shreg      <= '0;
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_shift) r_shreg <= w_word[WORD_BITS-2:0];
         if (w_load) r_word_out <= w_word;
         if (w_load) r_word_valid <= 1'b1;
         else if (i_word_taken) r_word_valid <= 1'b0;
         if (w_start) r_overrun <= 1'b0;
         else if (w_complete && !w_load) r_overrun <= 1'b1;
      end
endmodule

// File: tb/tb_atd_rx_controller.sv
// tb_atd_rx_controller: scoreboard bench; stimulus pushes expected words, a monitor
// pops one each time the DUT presents a new word.
module tb_atd_rx_controller;
   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        i_atd_clk = 1'b0, i_atd_data = 1'b0, i_atd_enable = 1'b0, i_word_taken = 1'b0;
   logic [15:0] o_word_out;
   logic        o_word_valid, o_frame_done, o_overrun, o_busy;

   int          checks = 0, fails = 0, done_cnt = 0;
   logic [15:0] sb[$];
   logic        auto_take = 1'b0;
   logic        m_prev_valid = 1'b0, m_prev_take = 1'b0;

   atd_rx_controller dut (
      .clk(clk), .n_rst(n_rst), .i_atd_clk(i_atd_clk), .i_atd_data(i_atd_data),
      .i_atd_enable(i_atd_enable), .i_word_taken(i_word_taken), .o_word_out(o_word_out),
      .o_word_valid(o_word_valid), .o_frame_done(o_frame_done), .o_overrun(o_overrun),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 1: assert taken in the completion cycle; mode 2: check valid rises exactly then
   task automatic send_bit(input logic b, input int mode);
      i_atd_data = b;
      cyc(2);
      i_atd_clk = 1'b1;
      cyc(2);
      if (mode == 1) i_word_taken = 1'b1;
      if (mode == 2) chk("valid_before_shift", o_word_valid, 0);
      cyc(1);
      if (mode == 1) i_word_taken = 1'b0;
      if (mode == 2) chk("valid_after_shift", o_word_valid, 1);
      i_atd_clk = 1'b0;
      cyc(2);
   endtask

   task automatic send_word(input logic [15:0] w, input int last_mode);
      for (int i = 15; i >= 0; i--) send_bit(w[i], (i == 0) ? last_mode : 0);
   endtask

   task automatic take();
      i_word_taken = 1'b1;
      cyc(1);
      i_word_taken = 1'b0;
      cyc(1);
   endtask

   always @(posedge clk) begin
      #1;
      if (auto_take) i_word_taken = o_word_valid && !i_word_taken;
   end

   always @(negedge clk) if (n_rst) begin
      if (o_word_valid && (!m_prev_valid || m_prev_take)) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) chk("word_out", o_word_out, sb.pop_front());
      end
      if (o_frame_done) begin
         done_cnt++;
         chk("done_after_take", m_prev_take, 1);
      end
      m_prev_valid = o_word_valid;
      m_prev_take  = o_word_valid & i_word_taken;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
      chk("rst_word_out", o_word_out, 0);
      chk("rst_valid", o_word_valid, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_overrun", o_overrun, 0);
      chk("rst_busy", o_busy, 0);
      n_rst = 1'b1;
      for (int i = 0; i < 20; i++) send_bit(i[0], 0);
      chk("idle_valid", o_word_valid, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_word_out", o_word_out, 0);

      i_atd_enable = 1'b1;
      cyc(2);
      chk("arm_busy", o_busy, 1);
      sb.push_back(16'hA5C3);
      send_word(16'hA5C3, 2);
      chk("single_overrun", o_overrun, 0);
      take();
      chk("taken_valid", o_word_valid, 0);
      sb.push_back(16'h1111);
      send_word(16'h1111, 0);
      send_word(16'h2222, 0);
      chk("ovr_word_out", o_word_out, 16'h1111);
      chk("ovr_flag", o_overrun, 1);
      chk("ovr_valid", o_word_valid, 1);
      i_atd_enable = 1'b0;
      cyc(1);
      chk("abort1_busy", o_busy, 0);
      chk("abort1_valid", o_word_valid, 1);
      cyc(2);
      chk("abort1_no_done", done_cnt, 0);
      take();
      i_atd_enable = 1'b1;
      cyc(1);
      chk("rearm_overrun", o_overrun, 0);
      chk("rearm_busy", o_busy, 1);

      sb.push_back(16'h2222);
      send_word(16'h2222, 0);
      sb.push_back(16'h3333);
      send_word(16'h3333, 1);
      chk("simul_valid", o_word_valid, 1);
      chk("simul_word_out", o_word_out, 16'h3333);
      chk("simul_overrun", o_overrun, 0);
      take();
      for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
      i_atd_enable = 1'b0;
      cyc(1);
      chk("abort2_busy", o_busy, 0);
      cyc(2);
      chk("abort2_no_done", done_cnt, 0);

      auto_take = 1'b1;
      i_atd_enable = 1'b1;
      cyc(2);
      for (int k = 1; k <= 8; k++) begin
         sb.push_back(16'(k));
         send_word(16'(k), 0);
      end
      i_atd_enable = 1'b0;
      cyc(3);
      auto_take = 1'b0;
      chk("frame_done_count", done_cnt, 1);
      chk("frame_busy", o_busy, 0);
      chk("frame_valid", o_word_valid, 0);
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/atd_rx_controller.md
Name: atd_rx_controller

Overview:
Sequences capture of one ATD serial frame into the system clock domain. Synchronises the asynchronous ATD_clk/ATD_data pair and generates a one-cycle shift strobe per ATD_clk rising edge. Assembles MSB-first words, hands them to the consumer over a valid/taken handshake, and signals frame completion. Sits between the ATD pins and the downstream word consumer.

Parameters:
WORD_BITS, 16, bits per delivered word (>=2)
FRAME_WORDS, 8, words per frame (default 128 bits)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
ATD_clk  in  1  asynchronous serial bit clock
ATD_data  in  1  serial data, stable around ATD_clk rising edge
atd_enable  in  1  level; high = frame capture armed/active
word_taken  in  1  consumer accepts word_out this cycle
word_out  out  WORD_BITS  held word, MSB = first received bit
word_valid  out  1  word_out holds an unconsumed word
frame_done  out  1  one-cycle pulse, frame fully delivered
overrun  out  1  sticky; a completed word was dropped
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: clk is clk, reset n_rst, asynchronous, active-low. All outputs 0, word_out 0, synchronisers 0, state IDLE, counters 0.
- Synchronisers: SYNC_STAGES flops each on ATD_clk and ATD_data, plus one edge-history flop. shift_en = sync_clk & ~prev_clk. Latency from ATD_clk rise to shift is SYNC_STAGES+1 clk cycles. Sampled bit = synchronised ATD_data in the shift_en cycle.
- States: IDLE, RECV, DRAIN, DONE.
- IDLE: shift_en ignored. If atd_enable=1, go to RECV, clear bit_cnt, word_cnt and overrun. Do not touch the holding register.
- RECV, on each shift_en:
  - shreg <= {shreg[WORD_BITS-2:0], bit}; bit_cnt++.
  - When bit_cnt==WORD_BITS-1, the word completes: word = {shreg[WORD_BITS-2:0], bit}; bit_cnt wraps to 0; word_cnt++.
  - On completion with the holding register empty, or with word_valid & word_taken in the same cycle: load word_out, word_valid=1 next cycle.
  - On completion with holding full and no word_taken: drop the word, set overrun=1. The held word is unchanged.
  - When word_cnt==FRAME_WORDS-1 at a completion, go to DRAIN.
- RECV abort: atd_enable=0 returns to IDLE next cycle and discards the partial word. Held word and word_valid remain. frame_done does not pulse.
- DRAIN: shift_en ignored. When word_valid==0, or word_valid & word_taken, go to DONE. atd_enable is ignored in this state.
- DONE: frame_done=1 for exactly this cycle, then IDLE. If atd_enable is still high, the next frame starts from IDLE on the following cycle (re-arm requires a pass through IDLE).
- Handshake: word_taken with word_valid clears word_valid next cycle, unless a new word loads in that same cycle. word_taken while word_valid=0 is ignored. word_out holds its value while valid.
- overrun: sticky; cleared only by reset or by an IDLE->RECV transition.
- Widths: bit_cnt is $clog2(WORD_BITS) bits and word_cnt is $clog2(FRAME_WORDS) bits, both wrapping exactly at their terminal values. No arithmetic overflow is allowed.
- Reset mid-frame: immediate return to the reset state. No frame_done.

Decomposition:
- Package atd_pkg: state enum typedef atd_rx_state_t {IDLE, RECV, DRAIN, DONE}; default constants ATD_WORD_BITS=16, ATD_FRAME_WORDS=8, ATD_SYNC_STAGES=2.
- Sub-module atd_edge_sync: parameterised synchroniser plus rising-edge detector. Outputs shift_en and sync_data. Used once.
- Bit and word counters reuse the existing flex_counter.

Test Plan:
- Reset: hold n_rst=0 while toggling ATD_clk -> all outputs 0. Release with atd_enable=0 and 20 ATD edges -> no word_valid, busy=0.
- Single word: atd_enable=1, send 0xA5C3 MSB-first with the consumer not taking -> word_valid rises SYNC_STAGES+2 cycles after the 16th edge, word_out=0xA5C3, overrun=0.
- Full frame: send words 0x0001..0x0008, taking each word 1 cycle after word_valid -> 8 words in order. frame_done pulses once, the cycle after the last word_taken. busy then drops to 0.
- Overrun: hold word_taken=0 across two words 0x1111, 0x2222 -> word_out stays 0x1111, overrun=1. Re-arm via IDLE with atd_enable -> overrun=0.
- Simultaneous: assert word_taken on the same cycle word 0x3333 completes while 0x2222 is held -> word_out=0x3333 next cycle, word_valid stays 1, overrun=0.
- Abort: drop atd_enable after 7 bits of word 3 -> IDLE next cycle, no frame_done. The next frame's first word is assembled from fresh bits only, with no stale partial bits.
